// File: rtl/op_exec_unit.sv
// op_exec_unit: execution stage behind the 3-to-8 opcode decoder.
// Accepts a one-hot opcode plus operand over a valid/ready handshake and
// applies it to an internal accumulator. LOAD/ADD/SUB/AND/OR/XOR/NOP retire
// one cycle after accept; MUL runs a WIDTH-cycle shift-add. Opcodes that are
// not one-hot take the single-cycle path, leave the accumulator alone and set
// a sticky error flag.
module op_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opCode,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             done,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]         r_op;
  logic [WIDTH-1:0]   r_opnd;     // operand; doubles as the shifting multiplier
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_zero;
  logic               r_done;
  logic               r_err;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_is_mul;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_carry;
  logic               w_write;
  logic               w_illegal;
  logic [2*WIDTH-1:0] w_prod_next;

  // Only the exact pattern 8'h80 is a MUL; anything else with bit 7 set is
  // not one-hot and must take the illegal (single-cycle) path.
  assign w_accept    = op_valid && (r_state == S_IDLE);
  assign w_is_mul    = (opCode == 8'h80);
  assign w_prod_next = r_prod + (r_opnd[0] ? r_mcand : '0);

  assign op_ready = (r_state == S_IDLE);
  assign acc      = r_acc;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign done     = r_done;
  assign err      = r_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: EXEC always retires in one cycle, MUL after WIDTH steps
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: w_state_next = S_IDLE;
      S_MUL: begin
        if (r_cnt == LAST_ITER) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Single-cycle ALU on the latched opcode/operand
  always_comb begin
    w_res       = r_acc;
    w_res_carry = r_carry;
    w_write     = 1'b0;
    w_illegal   = 1'b0;
    case (r_op)
      8'h01: ;  // NOP
      8'h02: begin
        w_write     = 1'b1;
        w_res       = r_opnd;
        w_res_carry = 1'b0;
      end
      8'h04: begin
        w_write                = 1'b1;
        {w_res_carry, w_res}   = {1'b0, r_acc} + {1'b0, r_opnd};
      end
      8'h08: begin
        // MSB of the widened difference is the borrow (acc < operand)
        w_write                = 1'b1;
        {w_res_carry, w_res}   = {1'b0, r_acc} - {1'b0, r_opnd};
      end
      8'h10: begin
        w_write     = 1'b1;
        w_res       = r_acc & r_opnd;
        w_res_carry = 1'b0;
      end
      8'h20: begin
        w_write     = 1'b1;
        w_res       = r_acc | r_opnd;
        w_res_carry = 1'b0;
      end
      8'h40: begin
        w_write     = 1'b1;
        w_res       = r_acc ^ r_opnd;
        w_res_carry = 1'b0;
      end
      8'h80: ;  // MUL never reaches EXEC
      default: w_illegal = 1'b1;
    endcase
  end

  // Datapath: latch on accept, execute, shift-add multiply, flags and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 8'h01;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op   <= opCode;
        r_opnd <= operand;
        if (w_is_mul) begin
          r_prod  <= '0;
          r_mcand <= {{WIDTH{1'b0}}, r_acc};
          r_cnt   <= '0;
        end
      end
      case (r_state)
        S_EXEC: begin
          r_done <= 1'b1;
          if (w_write) begin
            r_acc   <= w_res;
            r_carry <= w_res_carry;
            r_zero  <= (w_res == '0);
          end
          if (w_illegal) begin
            r_err <= 1'b1;
          end
        end
        S_MUL: begin
          r_prod  <= w_prod_next;
          r_mcand <= r_mcand << 1;
          r_opnd  <= r_opnd >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_acc   <= w_prod_next[WIDTH-1:0];
            r_carry <= |w_prod_next[2*WIDTH-1:WIDTH];
            r_zero  <= (w_prod_next[WIDTH-1:0] == '0);
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_exec_unit.sv
// Directed testbench for op_exec_unit (WIDTH=8) with hand-computed expectations.
module tb_op_exec_unit;

  logic       clk;
  logic       rst;
  logic [7:0] opCode;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] operand;
  logic [7:0] acc;
  logic       carry;
  logic       zero;
  logic       done;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  op_exec_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .opCode   (opCode),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .operand  (operand),
    .acc      (acc),
    .carry    (carry),
    .zero     (zero),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for retirement, check latency, busy time, results,
  // and that done drops after one cycle.
  task automatic do_op(input string tag, input logic [7:0] op, input logic [7:0] opd,
                       input int exp_lat, input logic [7:0] exp_acc,
                       input logic exp_c, input logic exp_z);
    int k;
    int lat;
    int busy;
    k = 0;
    while (!op_ready && k < 50) begin
      step();
      k++;
    end
    opCode   = op;
    operand  = opd;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    opCode   = 8'hFF;   // garbage after accept must be ignored
    operand  = 8'hA5;
    lat  = 0;
    busy = 0;
    while (!done && lat < 40) begin
      if (!op_ready) busy++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy"}, busy, exp_lat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_ready"}, op_ready, 1'b1);
    chk({tag, "_acc"}, acc, exp_acc);
    chk({tag, "_carry"}, carry, exp_c);
    chk({tag, "_zero"}, zero, exp_z);
    step();
    chk({tag, "_done_drop"}, done, 1'b0);
    $display("op %s opCode=%h operand=%h -> acc=%h carry=%b zero=%b latency=%0d",
             tag, op, opd, acc, carry, zero, lat);
  endtask

  initial begin
    int dones;
    rst      = 1'b1;
    opCode   = 8'h00;
    operand  = 8'h00;
    op_valid = 1'b0;

    // 1: reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_acc", acc, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_carry", carry, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_done", done, 1'b0);

    // 2: LOAD / ADD with carry out, NOP keeps flags
    do_op("LOAD05", 8'h02, 8'h05, 1, 8'h05, 1'b0, 1'b0);
    do_op("ADDFE",  8'h04, 8'hFE, 1, 8'h03, 1'b1, 1'b0);
    do_op("NOP",    8'h01, 8'h77, 1, 8'h03, 1'b1, 1'b0);

    // 3: SUB to zero, SUB with borrow
    do_op("SUB03",  8'h08, 8'h03, 1, 8'h00, 1'b0, 1'b1);
    do_op("SUB01",  8'h08, 8'h01, 1, 8'hFF, 1'b1, 1'b0);

    // Logic ops clear carry
    do_op("AND3C",  8'h10, 8'h3C, 1, 8'h3C, 1'b0, 1'b0);
    do_op("OR41",   8'h20, 8'h41, 1, 8'h7D, 1'b0, 1'b0);
    do_op("XORFF",  8'h40, 8'hFF, 1, 8'h82, 1'b0, 1'b0);
    do_op("XOR82",  8'h40, 8'h82, 1, 8'h00, 1'b0, 1'b1);

    // 4: MUL, 12*11=132, then 32*16=512 (overflow, low byte zero)
    do_op("LOAD0C", 8'h02, 8'h0C, 1, 8'h0C, 1'b0, 1'b0);
    do_op("MUL0B",  8'h80, 8'h0B, 8, 8'h84, 1'b0, 1'b0);
    do_op("LOAD20", 8'h02, 8'h20, 1, 8'h20, 1'b0, 1'b0);
    do_op("MUL10",  8'h80, 8'h10, 8, 8'h00, 1'b1, 1'b1);

    // 5: illegal opcode held across the busy cycle -> exactly one accept
    opCode   = 8'h03;
    operand  = 8'h11;
    op_valid = 1'b1;
    step();
    chk("ill_ready_low", op_ready, 1'b0);
    step();
    chk("ill_done", done, 1'b1);
    op_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) dones++;
    end
    chk("ill_single_accept", dones, 0);
    chk("ill_err", err, 1'b1);
    chk("ill_acc", acc, 8'h00);
    chk("ill_carry", carry, 1'b1);
    chk("ill_zero", zero, 1'b1);
    $display("op ILL03 held 2 cycles -> err=%b acc=%h extra_dones=%0d", err, acc, dones);
    do_op("ILL00",  8'h00, 8'h22, 1, 8'h00, 1'b1, 1'b1);
    do_op("LOAD55", 8'h02, 8'h55, 1, 8'h55, 1'b0, 1'b0);
    chk("err_sticky", err, 1'b1);

    // 6: async reset in the middle of a MUL
    do_op("LOAD07", 8'h02, 8'h07, 1, 8'h07, 1'b0, 1'b0);
    opCode   = 8'h80;
    operand  = 8'h09;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_acc", acc, 8'h00);
    chk("mr_carry", carry, 1'b0);
    chk("mr_zero", zero, 1'b1);
    chk("mr_done", done, 1'b0);
    chk("mr_err", err, 1'b0);
    chk("mr_ready", op_ready, 1'b1);
    dones = 0;
    repeat (2) begin
      step();
      if (done) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dones++;
    end
    chk("mr_no_done", dones, 0);
    chk("mr_acc_after", acc, 8'h00);
    $display("op MUL aborted by reset -> acc=%h err=%b dones=%0d", acc, err, dones);
    do_op("LOAD12", 8'h02, 8'h12, 1, 8'h12, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
